// File: rtl/inst_loader_if.sv
// Write port of the instruction loader: a word source pushes 32-bit
// instruction words with a valid/ready handshake and tags the last word.
interface inst_loader_if;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_last;
  logic        wr_ready;

  // Word source side
  modport master (
    output wr_valid,
    output wr_data,
    output wr_last,
    input  wr_ready
  );

  // Loader side
  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_last,
    output wr_ready
  );
endinterface

// File: rtl/inst_loader.sv
// Instruction loader: collects an instruction image into a buffer,
// pads the unloaded tail with FILL_WORD, holds the core in reset for
// RST_CYCLES cycles, then releases it and waits for the core to finish.
`ifndef DEF_MAX_INSTS
`define DEF_MAX_INSTS 16
`endif

module inst_loader #(
  parameter int          MAX_INSTS  = `DEF_MAX_INSTS,
  parameter int          RST_CYCLES = 4,
  parameter logic [31:0] FILL_WORD  = 32'h00000013
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [31:0]                 pc,
  input  logic                        core_finished,
  inst_loader_if.slave                wr,
  output logic [MAX_INSTS-1:0][31:0]  inst_buf,
  output logic [31:0]                 init_pc,
  output logic                        core_reset,
  output logic [31:0]                 count,
  output logic [2:0]                  state,
  output logic                        overflow,
  output logic                        done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    FILL = 3'd2,
    HOLD = 3'd3,
    RUN  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam int          IDXW      = (MAX_INSTS > 1) ? $clog2(MAX_INSTS) : 1;
  localparam logic [31:0] MAX_W     = 32'(MAX_INSTS);
  localparam logic [31:0] LAST_IDX  = 32'(MAX_INSTS - 1);
  localparam logic [31:0] HOLD_INIT = 32'(RST_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] fill_idx;
  logic [31:0] hold_cnt;
  logic        xfer;
  logic        has_room;
  logic [31:0] post_count;
  logic        begin_session;

  // State register; reset parks the loader in IDLE with the core held in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and handshake/core-reset outputs; start outranks everything
  always_comb begin
    xfer          = wr.wr_valid && (state_q == LOAD);
    has_room      = count < MAX_W;
    post_count    = (xfer && has_room) ? count + 32'd1 : count;
    state_d       = state_q;
    begin_session = 1'b0;
    wr.wr_ready   = (state_q == LOAD);
    core_reset    = !((state_q == RUN) || (state_q == DONE));
    state         = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = LOAD;
          begin_session = 1'b1;
        end
      end
      LOAD: begin
        if (start) begin
          state_d       = LOAD;
          begin_session = 1'b1;
        end else if (xfer && wr.wr_last) begin
          state_d = (post_count < MAX_W) ? FILL : HOLD;
        end
      end
      FILL: begin
        if (start) begin
          state_d       = LOAD;
          begin_session = 1'b1;
        end else if (fill_idx == LAST_IDX) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (start) begin
          state_d       = LOAD;
          begin_session = 1'b1;
        end else if (hold_cnt == 32'd0) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (start) begin
          state_d       = LOAD;
          begin_session = 1'b1;
        end else if (core_finished) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_d       = LOAD;
          begin_session = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Session bookkeeping: word count, entry PC, sticky flags, fill index and hold timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 32'd0;
      init_pc  <= 32'd0;
      overflow <= 1'b0;
      done     <= 1'b0;
      fill_idx <= 32'd0;
      hold_cnt <= 32'd0;
    end else if (begin_session) begin
      count    <= 32'd0;
      init_pc  <= pc;
      overflow <= 1'b0;
      done     <= 1'b0;
      fill_idx <= 32'd0;
      hold_cnt <= HOLD_INIT;
    end else begin
      case (state_q)
        LOAD: begin
          if (xfer) begin
            if (has_room) begin
              count <= count + 32'd1;
            end else begin
              overflow <= 1'b1;
            end
          end
          fill_idx <= post_count;
          hold_cnt <= HOLD_INIT;
        end
        FILL: begin
          fill_idx <= fill_idx + 32'd1;
          hold_cnt <= HOLD_INIT;
        end
        HOLD: begin
          if (hold_cnt != 32'd0) begin
            hold_cnt <= hold_cnt - 32'd1;
          end
        end
        RUN: begin
          if (core_finished) begin
            done <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Buffer storage is deliberately not reset; the core stays in reset until FILL/HOLD defines it
  always_ff @(posedge clk) begin
    if (!begin_session) begin
      if (xfer && has_room) begin
        inst_buf[count[IDXW-1:0]] <= wr.wr_data;
      end else if (state_q == FILL) begin
        inst_buf[fill_idx[IDXW-1:0]] <= FILL_WORD;
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader with depth 8 and a 2-cycle hold.
// Cycle-by-cycle vector tables cover the load/fill/hold/run flows;
// hand-written sequences cover buffer contents and asynchronous reset.
module tb_inst_loader;

  localparam int MAX_INSTS  = 8;
  localparam int RST_CYCLES = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic        start;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        fin;
    logic [2:0]  st;
    logic [31:0] cnt;
    logic        cr;
    logic        ov;
    logic        dn;
  } vec_t;

  logic                        clk;
  logic                        rst_n;
  logic                        start;
  logic [31:0]                 pc;
  logic                        core_finished;
  logic [MAX_INSTS-1:0][31:0]  inst_buf;
  logic [31:0]                 init_pc;
  logic                        core_reset;
  logic [31:0]                 count;
  logic [2:0]                  state;
  logic                        overflow;
  logic                        done;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  inst_loader_if bus ();

  inst_loader #(
    .MAX_INSTS  (MAX_INSTS),
    .RST_CYCLES (RST_CYCLES),
    .FILL_WORD  (NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .pc            (pc),
    .core_finished (core_finished),
    .wr            (bus),
    .inst_buf      (inst_buf),
    .init_pc       (init_pc),
    .core_reset    (core_reset),
    .count         (count),
    .state         (state),
    .overflow      (overflow),
    .done          (done)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic s, logic [31:0] p, logic v, logic [31:0] d,
                              logic l, logic f, logic [2:0] est, logic [31:0] ecnt,
                              logic ecr, logic eov, logic edn);
    vec_t r;
    r.start = s;   r.pc = p;     r.valid = v; r.data = d;
    r.last  = l;   r.fin = f;    r.st = est;  r.cnt = ecnt;
    r.cr    = ecr; r.ov = eov;   r.dn = edn;
    return r;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    start         = 1'b0;
    pc            = 32'd0;
    core_finished = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = 32'd0;
    bus.wr_last   = 1'b0;
  endtask

  task automatic step_idle();
    drive_idle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    start         = v.start;
    pc            = v.pc;
    core_finished = v.fin;
    bus.wr_valid  = v.valid;
    bus.wr_data   = v.data;
    bus.wr_last   = v.last;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input vec_t v, input string tag, input int idx);
    check_val($sformatf("%s[%0d].state", tag, idx), {29'd0, state}, {29'd0, v.st});
    check_val($sformatf("%s[%0d].count", tag, idx), count, v.cnt);
    check_val($sformatf("%s[%0d].core_reset", tag, idx), {31'd0, core_reset}, {31'd0, v.cr});
    check_val($sformatf("%s[%0d].overflow", tag, idx), {31'd0, overflow}, {31'd0, v.ov});
    check_val($sformatf("%s[%0d].done", tag, idx), {31'd0, done}, {31'd0, v.dn});
    check_val($sformatf("%s[%0d].wr_ready", tag, idx), {31'd0, bus.wr_ready},
              {31'd0, (v.st == 3'd1)});
  endtask

  task automatic run_vectors(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i], tag, i);
    end
    vecs.delete();
    drive_idle();
  endtask

  task automatic check_buf(input string tag, input int idx, input logic [31:0] exp);
    check_val($sformatf("%s.buf[%0d]", tag, idx), inst_buf[idx], exp);
  endtask

  // Main sequence: reset, table-driven phases, then asynchronous reset corner case
  initial begin
    drive_idle();
    rst_n = 1'b0;
    #12;
    check_val("reset.state", {29'd0, state}, 32'd0);
    check_val("reset.core_reset", {31'd0, core_reset}, 32'd1);
    check_val("reset.wr_ready", {31'd0, bus.wr_ready}, 32'd0);
    check_val("reset.count", count, 32'd0);
    check_val("reset.init_pc", init_pc, 32'd0);
    check_val("reset.overflow", {31'd0, overflow}, 32'd0);
    check_val("reset.done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_reset.idle", {29'd0, state}, 32'd0);

    // Basic image: three words, five fill cycles, two hold cycles, then run
    vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 3'd1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'hA, 0, 0, 3'd1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'hB, 0, 0, 3'd1, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'hC, 1, 0, 3'd2, 3, 1, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd2, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd3, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd3, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd4, 3, 0, 0, 0));
    run_vectors("basic");
    check_val("basic.init_pc", init_pc, 32'h100);
    check_buf("basic", 0, 32'hA);
    check_buf("basic", 1, 32'hB);
    check_buf("basic", 2, 32'hC);
    for (int i = 3; i < MAX_INSTS; i++) check_buf("basic", i, NOP);

    // Core finish in RUN, then an overflowing image with a stray finish pulse in LOAD
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd4, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3'd5, 3, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd5, 3, 0, 0, 1));
    vecs.push_back(mk(1, 32'h200, 0, 0, 0, 0, 3'd1, 0, 1, 0, 0));
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(mk(0, 0, 1, 32'h1000 + 32'(i), (i == 9), (i == 2),
                        (i == 9) ? 3'd3 : 3'd1, (i + 1 > 8) ? 32'd8 : 32'(i + 1),
                        1, (i >= 8), 0));
    end
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd3, 8, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd4, 8, 0, 1, 0));
    run_vectors("overflow");
    check_val("overflow.init_pc", init_pc, 32'h200);
    for (int i = 0; i < MAX_INSTS; i++) check_buf("overflow", i, 32'h1000 + 32'(i));

    // Abort RUN with a new session, then a gapped source
    vecs.push_back(mk(1, 32'h300, 0, 0, 0, 0, 3'd1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'hE1, 0, 0, 3'd1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'hDEAD, 0, 0, 3'd1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'hDEAD, 1, 0, 3'd1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'hE2, 0, 0, 3'd1, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'hE3, 1, 0, 3'd2, 3, 1, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd2, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd3, 3, 1, 0, 0));
    run_vectors("gapped");
    check_val("gapped.init_pc", init_pc, 32'h300);
    check_buf("gapped", 0, 32'hE1);
    check_buf("gapped", 1, 32'hE2);
    check_buf("gapped", 2, 32'hE3);
    for (int i = 3; i < MAX_INSTS; i++) check_buf("gapped", i, NOP);

    // Start during FILL, then start colliding with a transfer
    vecs.push_back(mk(1, 32'h400, 0, 0, 0, 0, 3'd1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h51, 1, 0, 3'd2, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'h450, 0, 0, 0, 0, 3'd1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h61, 0, 0, 3'd1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'h500, 1, 32'h62, 0, 0, 3'd1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h63, 1, 0, 3'd2, 1, 1, 0, 0));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd3, 1, 1, 0, 0));
    run_vectors("abort");
    check_val("abort.init_pc", init_pc, 32'h500);
    check_buf("abort", 0, 32'h63);
    for (int i = 1; i < MAX_INSTS; i++) check_buf("abort", i, NOP);

    // Asynchronous reset between edges while in HOLD
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async.state", {29'd0, state}, 32'd0);
    check_val("async.core_reset", {31'd0, core_reset}, 32'd1);
    check_val("async.done", {31'd0, done}, 32'd0);
    check_val("async.count", count, 32'd0);
    check_val("async.init_pc", init_pc, 32'd0);
    check_val("async.wr_ready", {31'd0, bus.wr_ready}, 32'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_idle();
      check_val($sformatf("async.idle[%0d].state", i), {29'd0, state}, 32'd0);
      check_val($sformatf("async.idle[%0d].core_reset", i), {31'd0, core_reset}, 32'd1);
    end
    vecs.push_back(mk(1, 32'h600, 0, 0, 0, 0, 3'd1, 0, 1, 0, 0));
    run_vectors("restart");
    check_val("restart.init_pc", init_pc, 32'h600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter MAX_INSTS, default `DEF_MAX_INSTS: instruction buffer depth in 32-bit words.
REQ-002 Parameter RST_CYCLES, default 4: cycles core_reset_ stays high after the image is complete.
REQ-003 Parameter FILL_WORD, default 32'h00000013 (NOP): value written to every unloaded entry.
REQ-004 _clk  input  1  single clock; all state changes on its rising edge.
REQ-005 _reset  input  1  asynchronous, active-low reset.
REQ-006 _start  input  1  one-cycle pulse that begins a new load session.
REQ-007 _pc  input  32  entry PC, sampled on the cycle _start is high.
REQ-008 _wr_valid  input  1  source presents a word.
REQ-009 _wr_data  input  32  instruction word.
REQ-010 _wr_last  input  1  marks the final word of the image; meaningful only with _wr_valid.
REQ-011 _core_finished  input  1  core ebreak indication.
REQ-012 wr_ready_  output  1  loader accepts a word this cycle.
REQ-013 inst_buf_  output  32 x MAX_INSTS  buffer contents driven to the core init-data port.
REQ-014 init_pc_  output  32  latched entry PC driven to the core init-PC port.
REQ-015 core_reset_  output  1  active-high reset driven to the core.
REQ-016 count_  output  32  words stored this session; saturates at MAX_INSTS.
REQ-017 state_  output  3  FSM state encoding.
REQ-018 overflow_  output  1  sticky flag: a word was dropped because the buffer was full.
REQ-019 done_  output  1  core has finished the current image.

Function
REQ-020 The FSM SHALL use these states: IDLE=0, LOAD=1, FILL=2, HOLD=3, RUN=4, DONE=5. All transitions take effect on the edge after the qualifying input.
REQ-021 wr_ready_ SHALL be 1 only in LOAD. A transfer is _wr_valid & wr_ready_ in the same cycle.
REQ-022 core_reset_ SHALL be 1 in IDLE, LOAD, FILL and HOLD, and 0 in RUN and DONE.
REQ-023 IDLE, or DONE, with _start=1 SHALL go to LOAD and, on that edge: count_ <= 0, init_pc_ <= _pc, overflow_ <= 0, done_ <= 0.
REQ-024 A LOAD transfer with count_ < MAX_INSTS SHALL write inst_buf_[count_] <= _wr_data and increment count_; write-to-visible latency is 1 cycle.
REQ-025 A LOAD transfer with count_ == MAX_INSTS SHALL drop the word, set overflow_, and leave count_ unchanged. wr_ready_ stays 1, so the source never stalls.
REQ-026 A transfer with _wr_last=1 SHALL leave LOAD:
- to FILL if the post-transfer count is < MAX_INSTS;
- otherwise to HOLD.
REQ-027 FILL SHALL write FILL_WORD to one entry per cycle, from index count_ up to MAX_INSTS-1, then go to HOLD. FILL lasts exactly MAX_INSTS-count_ cycles, and count_ is unchanged.
REQ-028 HOLD SHALL last exactly RST_CYCLES cycles (internal down-counter), then go to RUN. core_reset_ falls on the RUN entry edge.
REQ-029 RUN with _core_finished=1 SHALL go to DONE and set done_=1. _core_finished SHALL be ignored in every other state.
REQ-030 _start=1 in LOAD, FILL, HOLD or RUN SHALL abort the session and go to LOAD with the REQ-023 updates. core_reset_ SHALL be 1 from the next cycle.
REQ-031 _start SHALL have priority over a same-cycle transfer; that word is not stored and not counted.
REQ-032 _start and _core_finished together in RUN SHALL resolve as _start (LOAD), and done_ stays 0.
REQ-033 Unused state encodings 6-7 SHALL go to IDLE on the next edge.

Reset
REQ-034 _reset low SHALL immediately, without waiting for a clock, force these values:
- state_=IDLE, core_reset_=1, wr_ready_=0;
- count_=0, init_pc_=0, overflow_=0, done_=0;
- FILL and HOLD counters cleared.
REQ-035 inst_buf_ storage SHALL NOT be reset; its contents are defined only after FILL or HOLD is reached, and the core is held in reset until then.
REQ-036 Reset asserted mid-session (any state) SHALL discard the session, and a new _start is required after release.
REQ-037 The first edge after _reset rises SHALL be a normal edge; IDLE waits for _start.

Verification
REQ-038 MAX_INSTS=8, RST_CYCLES=2: _start with _pc=0x100, then words 0xA,0xB,0xC with last on 0xC -> inst_buf_ = {A,B,C, five 0x13}, count_=3, FILL 5 cycles, HOLD 2 cycles, then core_reset_=0 with init_pc_=0x100.
REQ-039 Gapped source (_wr_valid 1,0,0,1,1 with last on the third word) -> only the 3 valid words are stored, in order, and count_=3.
REQ-040 Ten words into depth 8, last on the tenth -> count_=8, overflow_=1, first 8 words retained, LOAD->HOLD directly with no FILL cycles.
REQ-041 RUN, pulse _core_finished -> state_=5, done_=1, core_reset_=0; the same pulse during LOAD -> no effect.
REQ-042 _start during FILL, and separately during a same-cycle transfer -> state_=1, count_=0, core_reset_=1, and the coincident word is not stored.
REQ-043 _reset low mid-HOLD, asynchronously between edges -> state_=0, core_reset_=1 and done_=0 without a clock edge; after release, stays in IDLE until _start.
